// File: rtl/tier2_pkg.sv
// Shared definitions for the tier-2 line-RAM scheduler: phase codes and default widths.
package tier2_pkg;

    localparam int DEF_WORD_WIDTH = 18;
    localparam int DEF_ADDR_WIDTH = 14;

    typedef enum logic [1:0] {
        PH_BUFFER = 2'd0,
        PH_TRUNC  = 2'd1,
        PH_GEN    = 2'd2,
        PH_FLUSH  = 2'd3
    } phase_e;

endpackage

// File: rtl/tier2_lram_arb_core.sv
// Single-port arbiter: phase-dependent priority with anti-starvation wait counters.
module tier2_lram_arb_core
    import tier2_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  phase_e phase,
    input  logic   wr_req,
    input  logic   rd_req,
    output logic   wr_gnt,
    output logic   rd_gnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wr_wait;
    logic [WAIT_W-1:0] rd_wait;
    logic              port_open;
    logic              wr_wins;

    always_comb begin
        port_open = (phase != PH_FLUSH);
        // wr_wins only matters when both sides request
        if (phase == PH_GEN) begin
            wr_wins = (wr_wait == WAIT_MAX);
        end else begin
            wr_wins = (rd_wait != WAIT_MAX);
        end
        wr_gnt = port_open && wr_req && (!rd_req || wr_wins);
        rd_gnt = port_open && rd_req && (!wr_req || !wr_wins);
    end

    // A requester that is open-phase, requesting and not granted has lost to the other side
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_wait <= '0;
            rd_wait <= '0;
        end else begin
            if (wr_gnt) begin
                wr_wait <= '0;
            end else if (port_open && wr_req && (wr_wait != WAIT_MAX)) begin
                wr_wait <= wr_wait + WAIT_W'(1);
            end
            if (rd_gnt) begin
                rd_wait <= '0;
            end else if (port_open && rd_req && (rd_wait != WAIT_MAX)) begin
                rd_wait <= rd_wait + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tier2_lram_scheduler.sv
// Tier-2 phase sequencer plus registered single-port line-RAM interface.
module tier2_lram_scheduler
    import tier2_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_WAIT   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  buffer_all_over,
    input  logic                  cal_truncation_point_over,
    input  logic                  codestream_generate_over,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  wr_gnt,
    output logic                  rd_gnt,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [WORD_WIDTH-1:0] ram_wdata,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic                  rd_data_valid,
    output logic                  cal_truncation_point_start,
    output logic                  codestream_generate_start,
    output logic                  rst_syn,
    output logic [1:0]            phase,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    // state     | meaning
    // PH_BUFFER | tier-1 code-blocks being buffered, writer has priority
    // PH_TRUNC  | truncation-point calculation, writer has priority
    // PH_GEN    | codestream generation, reader has priority
    // PH_FLUSH  | one-cycle clear of tier-2 blocks, port closed

    phase_e state;
    phase_e state_next;
    logic   cal_start_next;
    logic   gen_start_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= PH_BUFFER;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        cal_start_next = 1'b0;
        gen_start_next = 1'b0;
        case (state)
            PH_BUFFER: if (buffer_all_over) begin
                state_next     = PH_TRUNC;
                cal_start_next = 1'b1;
            end
            PH_TRUNC: if (cal_truncation_point_over) begin
                state_next     = PH_GEN;
                gen_start_next = 1'b1;
            end
            PH_GEN: if (codestream_generate_over) begin
                state_next = PH_FLUSH;
            end
            PH_FLUSH: state_next = PH_BUFFER;
            default:  state_next = PH_BUFFER;
        endcase
    end

    assign phase = state;

    tier2_lram_arb_core #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .phase  (state),
        .wr_req (wr_req),
        .rd_req (rd_req),
        .wr_gnt (wr_gnt),
        .rd_gnt (rd_gnt)
    );

    // ram_addr/ram_wdata hold their last value when no access is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_addr                   <= '0;
            ram_wdata                  <= '0;
            ram_we                     <= 1'b0;
            ram_re                     <= 1'b0;
            rd_data_valid              <= 1'b0;
            cal_truncation_point_start <= 1'b0;
            codestream_generate_start  <= 1'b0;
            rst_syn                    <= 1'b0;
            conflict_cnt               <= '0;
        end else begin
            ram_we        <= wr_gnt;
            ram_re        <= rd_gnt;
            rd_data_valid <= ram_re;
            if (wr_gnt) begin
                ram_addr  <= wr_addr;
                ram_wdata <= wr_data;
            end else if (rd_gnt) begin
                ram_addr <= rd_addr;
            end
            cal_truncation_point_start <= cal_start_next;
            codestream_generate_start  <= gen_start_next;
            rst_syn                    <= (state_next == PH_FLUSH);
            if (wr_req && rd_req && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_tier2_lram_scheduler.sv
// Self-checking bench for tier2_lram_scheduler: cycle model feeding an expected-RAM-op queue.
module tb_tier2_lram_scheduler;

    localparam int AW = 14;
    localparam int WW = 18;
    localparam int MW = 4;
    localparam int CW = 16;

    logic          clk;
    logic          rst;
    logic          buffer_all_over;
    logic          cal_truncation_point_over;
    logic          codestream_generate_over;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_gnt;
    logic          rd_gnt;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] ram_wdata;
    logic          ram_we;
    logic          ram_re;
    logic          rd_data_valid;
    logic          cal_truncation_point_start;
    logic          codestream_generate_start;
    logic          rst_syn;
    logic [1:0]    phase;
    logic [CW-1:0] conflict_cnt;

    tier2_lram_scheduler #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .MAX_WAIT   (MW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk                        (clk),
        .rst                        (rst),
        .buffer_all_over            (buffer_all_over),
        .cal_truncation_point_over  (cal_truncation_point_over),
        .codestream_generate_over   (codestream_generate_over),
        .wr_req                     (wr_req),
        .wr_addr                    (wr_addr),
        .wr_data                    (wr_data),
        .rd_req                     (rd_req),
        .rd_addr                    (rd_addr),
        .wr_gnt                     (wr_gnt),
        .rd_gnt                     (rd_gnt),
        .ram_addr                   (ram_addr),
        .ram_wdata                  (ram_wdata),
        .ram_we                     (ram_we),
        .ram_re                     (ram_re),
        .rd_data_valid              (rd_data_valid),
        .cal_truncation_point_start (cal_truncation_point_start),
        .codestream_generate_start  (codestream_generate_start),
        .rst_syn                    (rst_syn),
        .phase                      (phase),
        .conflict_cnt               (conflict_cnt)
    );

    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] addr;
        logic [WW-1:0] wdata;
    } ram_op_t;

    ram_op_t exp_q[$];
    int      checks   = 0;
    int      failures = 0;
    int      m_phase;
    int      m_wr_wait;
    int      m_rd_wait;
    int      m_conf;
    logic    m_prev_re;
    logic    last_wg;
    logic    last_rg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic cycle();
        logic    eg_w;
        logic    eg_r;
        int      nx;
        logic    e_cal;
        logic    e_gen;
        ram_op_t op;
        eg_w = 1'b0;
        eg_r = 1'b0;
        #1;
        if (m_phase != 3) begin
            if (wr_req && !rd_req) eg_w = 1'b1;
            else if (rd_req && !wr_req) eg_r = 1'b1;
            else if (wr_req && rd_req) begin
                if (m_phase == 2) begin
                    if (m_wr_wait >= MW) eg_w = 1'b1; else eg_r = 1'b1;
                end else begin
                    if (m_rd_wait >= MW) eg_r = 1'b1; else eg_w = 1'b1;
                end
            end
        end
        check_eq("wr_gnt", wr_gnt, eg_w);
        check_eq("rd_gnt", rd_gnt, eg_r);
        last_wg = eg_w;
        last_rg = eg_r;
        op.we    = eg_w;
        op.re    = eg_r;
        op.addr  = eg_w ? wr_addr : rd_addr;
        op.wdata = wr_data;
        exp_q.push_back(op);

        if (eg_w) m_wr_wait = 0;
        else if (wr_req && m_phase != 3) m_wr_wait++;
        if (eg_r) m_rd_wait = 0;
        else if (rd_req && m_phase != 3) m_rd_wait++;
        if (wr_req && rd_req && m_conf < 65535) m_conf++;

        nx    = m_phase;
        e_cal = 1'b0;
        e_gen = 1'b0;
        case (m_phase)
            0: if (buffer_all_over) begin nx = 1; e_cal = 1'b1; end
            1: if (cal_truncation_point_over) begin nx = 2; e_gen = 1'b1; end
            2: if (codestream_generate_over) nx = 3;
            default: nx = 0;
        endcase
        m_phase = nx;

        @(posedge clk);
        #1;
        op = exp_q.pop_front();
        check_eq("ram_we", ram_we, op.we);
        check_eq("ram_re", ram_re, op.re);
        if (op.we || op.re) check_eq("ram_addr", ram_addr, op.addr);
        if (op.we) check_eq("ram_wdata", ram_wdata, op.wdata);
        check_eq("rd_data_valid", rd_data_valid, m_prev_re);
        m_prev_re = op.re;
        check_eq("phase", phase, m_phase);
        check_eq("cal_start", cal_truncation_point_start, e_cal);
        check_eq("gen_start", codestream_generate_start, e_gen);
        check_eq("rst_syn", rst_syn, (m_phase == 3));
        check_eq("conflict_cnt", conflict_cnt, m_conf);

        @(negedge clk);
        buffer_all_over           = 1'b0;
        cal_truncation_point_over = 1'b0;
        codestream_generate_over  = 1'b0;
    endtask

    task automatic do_reset();
        wr_req = 1'b0;
        rd_req = 1'b0;
        buffer_all_over           = 1'b0;
        cal_truncation_point_over = 1'b0;
        codestream_generate_over  = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("rst_phase", phase, 0);
        check_eq("rst_gnt", {wr_gnt, rd_gnt}, 0);
        check_eq("rst_ram_ctl", {ram_we, ram_re, rd_data_valid}, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        check_eq("rst_pulses", {cal_truncation_point_start, codestream_generate_start, rst_syn}, 0);
        check_eq("rst_conflict", conflict_cnt, 0);
        m_phase   = 0;
        m_wr_wait = 0;
        m_rd_wait = 0;
        m_conf    = 0;
        m_prev_re = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic goto_gen();
        buffer_all_over = 1'b1;
        cycle();
        cal_truncation_point_over = 1'b1;
        cycle();
    endtask

    initial begin
        int pat[7];
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        buffer_all_over           = 1'b0;
        cal_truncation_point_over = 1'b0;
        codestream_generate_over  = 1'b0;
        #1;
        do_reset();

        // writer priority in BUFFER
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 14'h0123; wr_data = 18'h2ABCD; rd_addr = 14'h0456;
        for (int i = 0; i < 3; i++) begin
            wr_data = wr_data + 18'd1;
            cycle();
            check_eq("prio_wr", last_wg, 1'b1);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        check_eq("prio_conflict", conflict_cnt, 3);
        idle(1);

        // stray done pulse in BUFFER
        codestream_generate_over = 1'b1;
        cycle();
        check_eq("stray_phase", phase, 0);
        cal_truncation_point_over = 1'b1;
        cycle();

        // phase walk, with both requests held during FLUSH
        do_reset();
        buffer_all_over = 1'b1;
        cycle();
        idle(4);
        cal_truncation_point_over = 1'b1;
        cycle();
        idle(9);
        codestream_generate_over = 1'b1;
        cycle();
        check_eq("walk_flush", phase, 3);
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 14'h0777; rd_addr = 14'h0888;
        cycle();
        wr_req = 1'b0; rd_req = 1'b0;
        check_eq("walk_back", phase, 0);
        idle(2);

        // starvation relief in GEN
        do_reset();
        goto_gen();
        pat = '{1, 1, 1, 1, 0, 1, 1};
        wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 14'h1000; rd_addr = 14'h2000; wr_data = 18'h15555;
        for (int i = 0; i < 7; i++) begin
            cycle();
            check_eq("starve_rd", last_rg, pat[i]);
        end
        wr_req = 1'b0; rd_req = 1'b0;
        idle(1);

        // read latency
        rd_req = 1'b1; rd_addr = 14'h01A5;
        cycle();
        rd_req = 1'b0;
        check_eq("lat_re", ram_re, 1'b1);
        check_eq("lat_addr", ram_addr, 14'h01A5);
        cycle();
        check_eq("lat_valid", rd_data_valid, 1'b1);
        idle(1);

        // read in the last GEN cycle still returns data after FLUSH
        rd_req = 1'b1; rd_addr = 14'h0333;
        codestream_generate_over = 1'b1;
        cycle();
        rd_req = 1'b0;
        cycle();
        check_eq("late_valid", rd_data_valid, 1'b1);
        idle(1);

        // reset with a read in flight
        goto_gen();
        rd_req = 1'b1; rd_addr = 14'h0444;
        cycle();
        rd_req = 1'b0;
        do_reset();
        idle(2);

        // mixed traffic across phases
        for (int i = 0; i < 60; i++) begin
            wr_req  = 1'($urandom_range(0, 1));
            rd_req  = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom);
            wr_data = WW'($urandom);
            rd_addr = AW'($urandom);
            buffer_all_over           = ($urandom_range(0, 5) == 0);
            cal_truncation_point_over = ($urandom_range(0, 5) == 0);
            codestream_generate_over  = ($urandom_range(0, 5) == 0);
            cycle();
        end
        wr_req = 1'b0; rd_req = 1'b0;
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
